lzc_norm_pipe: RTL and testbench

- Normalization stage directly downstream of the 28-bit leading-zero counter.
- Takes the raw mantissa plus the counter's zero_num / is_zero results and a biased exponent.
- Left-shifts the mantissa so its MSB is set and decrements the exponent by the applied shift; clamps to a denormal at exponent 0.
- Two-stage valid/ready pipeline feeding the float pack/round stage.

---
 rtl/lzc_norm_pipe.sv | 81 ++++++++
 tb/tb_lzc_norm_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage valid/ready normalizer after the LZC; optional underflow counter via LZC_NORM_UF_CNT_EN
module lzc_norm_pipe #(
  parameter int DATA_WIDTH = 28,
  parameter int CNT_WIDTH  = 5,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  zero_num,
  input  logic                  is_zero,
  input  logic [EXP_WIDTH-1:0]  exp_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [EXP_WIDTH-1:0]  exp_out,
  output logic                  zero_out,
  output logic                  underflow
`ifdef LZC_NORM_UF_CNT_EN
  ,output logic [15:0]          uf_count
`endif
);
  localparam int MW = CNT_WIDTH > EXP_WIDTH ? CNT_WIDTH : EXP_WIDTH;
  logic                  s1_valid, s1_uf, s1_zero, s1_adv, s2_adv;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CNT_WIDTH-1:0]  s1_shift;
  logic [EXP_WIDTH-1:0]  s1_exp;
  logic [MW-1:0]         zn_ext, ex_ext;
  logic [DATA_WIDTH-1:0] lvl [CNT_WIDTH+1];
  assign zn_ext   = MW'(zero_num);
  assign ex_ext   = MW'(exp_in);
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  // log shifter; any amount >= DATA_WIDTH shifts every bit out and leaves zero
  assign lvl[0] = s1_data;
  for (genvar i = 0; i < CNT_WIDTH; i++) begin : g_shift
    assign lvl[i+1] = s1_shift[i] ? lvl[i] << (1 << i) : lvl[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shift <= '0;
      s1_exp   <= '0;
      s1_uf    <= 1'b0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      s1_data  <= data_in;
      s1_shift <= CNT_WIDTH'(zn_ext < ex_ext ? zn_ext : ex_ext);
      s1_exp   <= exp_in;
      s1_uf    <= (zn_ext > ex_ext) & ~is_zero;
      s1_zero  <= is_zero;
    end
  end
  // shift never exceeds s1_exp, so the subtraction cannot wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      exp_out   <= '0;
      zero_out  <= 1'b0;
      underflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      data_out  <= s1_zero ? '0 : lvl[CNT_WIDTH];
      exp_out   <= (s1_zero | s1_uf) ? '0 : s1_exp - EXP_WIDTH'(s1_shift);
      zero_out  <= s1_zero;
      underflow <= s1_uf;
    end
  end
`ifdef LZC_NORM_UF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) uf_count <= '0;
    else if (out_valid & out_ready & underflow & ~&uf_count) uf_count <= uf_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// tb_lzc_norm_pipe: randomized and directed scoreboard bench for lzc_norm_pipe
module tb_lzc_norm_pipe;
  logic        clk = 1'b0, rst, in_valid, in_ready, is_zero, out_valid, out_ready, zero_out, underflow;
  logic [27:0] data_in, data_out;
  logic [4:0]  zero_num;
  logic [7:0]  exp_in, exp_out;
`ifdef LZC_NORM_UF_CNT_EN
  logic [15:0] uf_count;
`endif
  typedef struct packed {logic [27:0] d; logic [7:0] e; logic z; logic u;} beat_t;
  beat_t expq[$];
  int n_checks = 0, n_pass = 0;
  logic [27:0] td [6] = '{28'h0000001, 28'h0000100, 28'h0, 28'h0000010, 28'h0000100, 28'h0ABCDEF};
  logic [4:0]  tn [6] = '{5'd27, 5'd19, 5'd0, 5'd23, 5'd19, 5'd30};
  logic        tz [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0]  te [6] = '{8'd100, 8'd5, 8'd50, 8'd23, 8'd0, 8'd200};

  lzc_norm_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .zero_num(zero_num), .is_zero(is_zero), .exp_in(exp_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .exp_out(exp_out), .zero_out(zero_out),
    .underflow(underflow)
`ifdef LZC_NORM_UF_CNT_EN
    , .uf_count(uf_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic beat_t model(input logic [27:0] d, input int zn, input logic z, input int e);
    beat_t b;
    int sh;
    b = '0;
    if (z) begin
      b.z = 1'b1;
      return b;
    end
    sh = zn < e ? zn : e;
    b.d = sh >= 28 ? 28'd0 : d << sh;
    b.e = 8'(e - sh);
    b.u = zn > e;
    return b;
  endfunction

  function automatic int lzc(input logic [27:0] d);
    for (int i = 27; i >= 0; i--) if (d[i]) return 27 - i;
    return 28;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; zero_num = '0; is_zero = 1'b0; exp_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expq.delete();
  endtask

  task automatic step(input logic v, input logic [27:0] d, input logic [4:0] zn, input logic z,
                      input logic [7:0] e, input logic ordy, output logic ir, output logic ov,
                      output logic acc, output logic xfer, output beat_t o);
    in_valid = v; data_in = d; zero_num = zn; is_zero = z; exp_in = e; out_ready = ordy;
    #1;
    ir = in_ready; ov = out_valid; acc = v & in_ready; xfer = out_valid & ordy;
    o = {data_out, exp_out, zero_out, underflow};
    if (acc) expq.push_back(model(d, int'(zn), z, int'(e)));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({out_valid, data_out, exp_out, zero_out, underflow} !== '0)
      $display("FAIL reset_outputs: got %h expected 0", {out_valid, data_out, exp_out, zero_out, underflow});
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
`ifdef LZC_NORM_UF_CNT_EN
    n_checks++;
    if (uf_count !== 16'd0) $display("FAIL reset_uf_count: got %0d expected 0", uf_count);
    else n_pass++;
`endif
  endtask

  task automatic test_directed();
    logic ir, ov, acc, xfer;
    beat_t o, x;
    int ucnt = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, td[i], tn[i], tz[i], te[i], 1'b1, ir, ov, acc, xfer, o);
      n_checks++;
      if (!acc) $display("FAIL dir_accept%0d: got 0 expected 1", i);
      else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, acc, xfer, o);
      n_checks++;
      if (ov !== 1'b0) $display("FAIL dir_fill%0d: got out_valid %b expected 0", i, ov);
      else n_pass++;
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, acc, xfer, o);
      n_checks++;
      if (!xfer || expq.size() == 0) $display("FAIL dir_latency%0d: got xfer %b expected 1", i, xfer);
      else begin
        x = expq.pop_front();
        ucnt += int'(x.u);
        if (o !== x) $display("FAIL dir_beat%0d: got %h expected %h", i, o, x);
        else n_pass++;
      end
    end
`ifdef LZC_NORM_UF_CNT_EN
    n_checks++;
    if (uf_count !== 16'(ucnt)) $display("FAIL dir_uf_count: got %0d expected %0d", uf_count, ucnt);
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    logic ir, ov, acc, xfer;
    beat_t o, x, held;
    int sent = 0;
    do_reset();
    held = '0;
    for (int c = 0; c < 5; c++) begin
      step(sent < 3, 28'h4000000, 5'd1, 1'b0, 8'(10 + sent), 1'b0, ir, ov, acc, xfer, o);
      if (acc) sent++;
      if (c >= 2) begin
        n_checks++;
        if (ir !== 1'b0 || sent != 2) $display("FAIL bp_in_ready: got in_ready %b sent %0d expected 0 and 2", ir, sent);
        else n_pass++;
        n_checks++;
        if (ov !== 1'b1) $display("FAIL bp_out_valid: got %b expected 1", ov);
        else n_pass++;
        if (c == 2) held = o;
        else begin
          n_checks++;
          if (o !== held) $display("FAIL bp_stable: got %h expected %h", o, held);
          else n_pass++;
        end
      end
    end
    for (int c = 0; c < 20 && (sent < 3 || expq.size() > 0); c++) begin
      step(sent < 3, 28'h4000000, 5'd1, 1'b0, 8'(10 + sent), 1'b1, ir, ov, acc, xfer, o);
      if (acc) sent++;
      if (xfer) begin
        n_checks++;
        if (expq.size() == 0) $display("FAIL bp_extra: got %h expected none", o);
        else begin
          x = expq.pop_front();
          if (o !== x) $display("FAIL bp_beat: got %h expected %h", o, x);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (sent != 3 || expq.size() != 0) $display("FAIL bp_drain: got sent %0d left %0d expected 3 and 0", sent, expq.size());
    else n_pass++;
  endtask

  task automatic test_streaming();
    logic ir, ov, acc, xfer, z;
    logic [27:0] d;
    beat_t o, x;
    do_reset();
    for (int i = 0; i < 102; i++) begin
      d = 28'($urandom() >> $urandom_range(4, 31));
      z = d == 0;
      step(i < 100, d, z ? 5'd0 : 5'(lzc(d)), z, 8'($urandom_range(0, 60)), 1'b1, ir, ov, acc, xfer, o);
      if (i < 100) begin
        n_checks++;
        if (!acc) $display("FAIL stream_accept%0d: got 0 expected 1", i);
        else n_pass++;
      end
      n_checks++;
      if (xfer !== (i >= 2)) $display("FAIL stream_rate%0d: got xfer %b expected %b", i, xfer, i >= 2);
      else if (xfer) begin
        if (expq.size() == 0) $display("FAIL stream_extra: got %h expected none", o);
        else begin
          x = expq.pop_front();
          if (o !== x) $display("FAIL stream_beat%0d: got %h expected %h", i, o, x);
          else n_pass++;
        end
      end else n_pass++;
    end
    n_checks++;
    if (expq.size() != 0) $display("FAIL stream_left: got %0d expected 0", expq.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ir, ov, acc, xfer, z;
    logic [27:0] d;
    beat_t o, x;
    do_reset();
    for (int i = 0; i < 320; i++) begin
      d = 28'($urandom() >> $urandom_range(4, 31));
      z = d == 0;
      step(i < 300 && $urandom_range(0, 3) != 0, d, z ? 5'd0 : 5'(lzc(d)), z,
           8'($urandom_range(0, 40)), i >= 300 || $urandom_range(0, 9) < 7, ir, ov, acc, xfer, o);
      if (xfer) begin
        n_checks++;
        if (expq.size() == 0) $display("FAIL b2b_extra: got %h expected none", o);
        else begin
          x = expq.pop_front();
          if (o !== x) $display("FAIL b2b_beat: got %h expected %h", o, x);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (expq.size() != 0) $display("FAIL b2b_left: got %0d expected 0", expq.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic ir, ov, acc, xfer;
    beat_t o, x;
    do_reset();
    step(1'b1, 28'h0000100, 5'd19, 1'b0, 8'd5, 1'b1, ir, ov, acc, xfer, o);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, acc, xfer, o);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, acc, xfer, o);
    n_checks++;
    if (!xfer || expq.size() == 0) $display("FAIL mid_pre: got xfer %b expected 1", xfer);
    else begin
      x = expq.pop_front();
      if (o !== x) $display("FAIL mid_pre_beat: got %h expected %h", o, x);
      else n_pass++;
    end
    step(1'b1, 28'h0000100, 5'd19, 1'b0, 8'd5, 1'b0, ir, ov, acc, xfer, o);
    step(1'b1, 28'h0000001, 5'd27, 1'b0, 8'd2, 1'b0, ir, ov, acc, xfer, o);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expq.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready);
    else n_pass++;
`ifdef LZC_NORM_UF_CNT_EN
    n_checks++;
    if (uf_count !== 16'd0) $display("FAIL mid_uf_count: got %0d expected 0", uf_count);
    else n_pass++;
`endif
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, acc, xfer, o);
      n_checks++;
      if (ov !== 1'b0) $display("FAIL mid_stale%0d: got out_valid %b expected 0", i, ov);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
